// File: rtl/add16_stream_ctrl.sv
// add16_stream_ctrl
//
// Registered stream wrapper around an external combinational adder.
// Operand pairs enter through a valid/ready handshake and sit in a 2-entry
// FIFO. They move into an operand register (S1) that drives the adder. The
// adder's sum and overflow are captured into a result register (S2), which
// is presented downstream through a valid/ready handshake. The block also
// keeps statistics on transferred results.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid/in_ready    input handshake; in_a/in_b carry the operand pair
//   add_a/add_b          operands to the adder (straight from S1)
//   add_sum/add_ovf      adder result (combinational from add_a/add_b)
//   out_valid/out_ready  output handshake; out_sum/out_ovf carry the result
//   clr_stats            single-cycle clear of the statistics
//   ops_count            results transferred, wraps modulo 2^16
//   ovf_count            overflowing results transferred, saturating
//   ovf_sticky           set by any overflowing transfer
module add16_stream_ctrl #(
  parameter int WIDTH     = 16,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_ovf,
  input  logic                 clr_stats,
  output logic [15:0]          ops_count,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 ovf_sticky
);

  // FIFO storage and pointers
  logic [WIDTH-1:0] r_fifo_a [2];
  logic [WIDTH-1:0] r_fifo_b [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_fifo_count;

  // S1 operand register and S2 result register
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s2_sum;
  logic             r_s2_ovf;
  logic             r_s2_valid;

  // Statistics
  logic [15:0]          r_ops_count;
  logic [OVF_CNT_W-1:0] r_ovf_count;
  logic                 r_ovf_sticky;

  logic w_fifo_nonempty;
  logic w_fifo_push;
  logic w_fifo_pop;
  logic w_s1_load;
  logic w_s2_load;
  logic w_out_xfer;

  // in_ready depends only on the registered FIFO count, so there is no
  // combinational path from out_ready back to the input side.
  assign in_ready        = (r_fifo_count < 2'd2);
  assign w_fifo_nonempty = (r_fifo_count != 2'd0);
  assign w_fifo_push     = in_valid && in_ready;
  assign w_s2_load       = r_s1_valid && (!r_s2_valid || out_ready);
  assign w_s1_load       = w_fifo_nonempty && (!r_s1_valid || w_s2_load);
  assign w_fifo_pop      = w_s1_load;
  assign w_out_xfer      = r_s2_valid && out_ready;

  // FIFO: 2 entries with 1-bit pointers that wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_a[i] <= '0;
        r_fifo_b[i] <= '0;
      end
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_fifo_count <= 2'd0;
    end else begin
      if (w_fifo_push) begin
        r_fifo_a[r_wr_ptr] <= in_a;
        r_fifo_b[r_wr_ptr] <= in_b;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({w_fifo_push, w_fifo_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
        2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // S1 holds its operands until S2 takes the sum, keeping add_a/add_b stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_a     <= r_fifo_a[r_rd_ptr];
        r_s1_b     <= r_fifo_b[r_rd_ptr];
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // S2 captures the adder result computed from the current S1 contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_sum   <= '0;
      r_s2_ovf   <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_sum   <= add_sum;
        r_s2_ovf   <= add_ovf;
        r_s2_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  // Statistics. A clear coinciding with a transfer restarts the counts
  // with that transfer already included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ops_count  <= '0;
      r_ovf_count  <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (clr_stats) begin
      r_ops_count  <= w_out_xfer ? 16'd1 : 16'd0;
      r_ovf_count  <= (w_out_xfer && r_s2_ovf) ? OVF_CNT_W'(1) : '0;
      r_ovf_sticky <= w_out_xfer && r_s2_ovf;
    end else if (w_out_xfer) begin
      r_ops_count <= r_ops_count + 16'd1;
      if (r_s2_ovf) begin
        if (!(&r_ovf_count)) begin
          r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
        end
        r_ovf_sticky <= 1'b1;
      end
    end
  end

  assign add_a      = r_s1_a;
  assign add_b      = r_s1_b;
  assign out_valid  = r_s2_valid;
  assign out_sum    = r_s2_sum;
  assign out_ovf    = r_s2_ovf;
  assign ops_count  = r_ops_count;
  assign ovf_count  = r_ovf_count;
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: doc/add16_stream_ctrl.md
# add16_stream_ctrl

Registered stream wrapper that sits directly upstream and downstream of the 16-bit combinational prefix adder in the pipelined adder. It accepts operand pairs over a valid/ready handshake, buffers them in a 2-entry skid FIFO, and drives them to the adder from an operand register. It captures the adder's sum and overflow into a result register and presents them on a valid/ready output. It also keeps a completed-operation count, a saturating overflow count and a sticky overflow flag.

## Interface
Parameters:
- WIDTH, 16, operand and sum width; must match the adder instance.
- OVF_CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair on in_a/in_b is valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- add_a  out  WIDTH  operand A driven to the adder, taken straight from the S1 register.
- add_b  out  WIDTH  operand B driven to the adder, taken straight from the S1 register.
- add_sum  in  WIDTH  adder sum; combinational from add_a/add_b.
- add_ovf  in  1  adder overflow; equals carry-out of bit WIDTH-1.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  registered sum.
- out_ovf  out  1  registered overflow.
- clr_stats  in  1  one-cycle pulse that clears the statistics.
- ops_count  out  16  results transferred out; wraps modulo 2^16.
- ovf_count  out  OVF_CNT_W  results transferred with out_ovf=1; saturates at all-ones.
- ovf_sticky  out  1  set by any transferred overflow; cleared only by clr_stats or reset.

## Operation
- **Pipeline stages:**
  - FIFO: 2 entries, in order.
  - S1: operand register plus valid bit; drives add_a/add_b.
  - S2: result register plus valid bit; drives out_*.
- **Handshakes:**
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid is the S2 valid bit.
  - Once out_valid rises, out_sum/out_ovf hold stable until the transfer.
- **Advance rules, evaluated in the same cycle:**
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = fifo_nonempty && (!s1_valid || s2_load).
  - fifo_pop = s1_load.
  - fifo_push = in_valid && in_ready.
- **in_ready:** in_ready = (fifo_count < 2). It is computed from registered count only, with no combinational path from out_ready. Push and pop in the same cycle at count=2 is impossible because in_ready=0.
- **FIFO:** a simultaneous push and pop at count 1 leaves count at 1, with correct ordering. The read and write pointers wrap modulo 2.
- **S2 capture:** on s2_load, S2 captures add_sum and add_ovf, which are computed from the current S1 contents. When S2 is not loading, S1 holds its contents; add_a/add_b therefore stay stable.
- **Statistics, per cycle:**
  - Output transfer: ops_count increments by 1, wrapping from 0xFFFF to 0.
  - Output transfer with out_ovf=1: ovf_count increments unless it is already all-ones; ovf_sticky is set.
  - clr_stats=1: all three statistics go to 0 that cycle. If a transfer coincides with the clear, the clear wins but the transfer is then counted: ops_count=1, ovf_count=out_ovf, ovf_sticky=out_ovf.
- **Reset (rst_n=0 at an edge):** empties the FIFO and clears the S1 and S2 valid bits and all statistics.
  - Data registers reset to 0.
  - In-flight operands are discarded, including a reset asserted mid-stream.

## Timing
- **Reset values:**
  - in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
  - add_a=0, add_b=0.
  - ops_count=0, ovf_count=0, ovf_sticky=0.
- **Latency (empty pipe, out_ready=1):**
  - Push at edge E0.
  - FIFO to S1 at E1.
  - S1 to S2 at E2; out_valid=1 after E2, so 3 edges.
- **Throughput:** 1 result per cycle while in_valid=1 and out_ready=1.
- **Backpressure:** with out_ready held low, the block absorbs exactly 4 operand pairs (FIFO 2 + S1 + S2); in_ready falls after the 4th accept. When out_ready rises, one transfer per cycle resumes and in_ready returns the edge after the FIFO pops.
- **Combinational path:** the adder path add_a to add_sum to the S2 register must close within one clock.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, all outputs and statistics 0; no accept is recorded.
- **Single add:** a=0x1234, b=0x1111 pushed at E0 → out_valid=1 after E2, out_sum=0x2345, out_ovf=0, ops_count=1 after transfer.
- **Carry out:** a=0xFFFF, b=0x0001 → out_sum=0x0000, out_ovf=1; ovf_count=1, ovf_sticky=1 after transfer.
- **Streaming with backpressure:** push 6 pairs (i, 2i) for i=1..6 with out_ready=0 → in_ready falls after 4 accepts. Then raise out_ready → sums 3,6,9,12,15,18 appear in order, with no loss or duplication, and ops_count=6.
- **Overflow saturation:** with OVF_CNT_W=2, transfer 5 overflowing results (0x8000+0x8000) → ovf_count=3, out_sum=0x0000 each time.
- **Clear during transfer:** pulse clr_stats in the same cycle as an overflowing transfer → ops_count=1, ovf_count=1, ovf_sticky=1. Assert rst_n=0 mid-stream → out_valid=0 next edge and no stale results afterwards.
